// File: rtl/xyrgb_key_loader_if.sv
// Front-panel bus: slide switches and push buttons in, X/Y/RGB registers and update pulse out.
interface xyrgb_key_loader_if;
  logic [9:0] SW;
  logic [3:0] KEY;
  logic [7:0] Xin;
  logic [7:0] Yin;
  logic [8:0] RGBin;
  logic       upd;

  modport master (output SW, KEY, input Xin, Yin, RGBin, upd);
  modport slave  (input SW, KEY, output Xin, Yin, RGBin, upd);
endinterface

// File: rtl/xyrgb_key_loader.sv
// Debounced push-button loader for the X, Y and RGB drawing registers.
// Optional macro XYRGB_STEP_EN: KEY[0] steps the {Y,X} position by one.
module xyrgb_key_lane #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          stable;
  logic [CW-1:0] cnt;

  // Counter flips the stable state on its last step instead of reaching the limit, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= 2'b11;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync  <= {sync[0], key};
      press <= 1'b0;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync[1];
        cnt    <= '0;
        press  <= ~sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module xyrgb_key_loader #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic              clk,
  input logic              RST,
  xyrgb_key_loader_if.slave bus
);
`ifdef XYRGB_STEP_EN
  localparam int FIRST_KEY = 0;
`else
  localparam int FIRST_KEY = 1;
`endif

  logic [3:0] press;
  logic [7:0] x_nxt, y_nxt;
  logic [8:0] rgb_nxt;
  logic       unused_sw;

  assign unused_sw = bus.SW[9];

  generate
    for (genvar k = 0; k < 4; k++) begin : g_lane
      if (k >= FIRST_KEY) begin : g_on
        xyrgb_key_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
          .clk   (clk),
          .rst   (RST),
          .key   (bus.KEY[k]),
          .press (press[k])
        );
      end else begin : g_off
        logic unused_key;
        assign unused_key = bus.KEY[k];
        assign press[k]   = 1'b0;
      end
    end
  endgenerate

  // Loads are applied after the step so a KEY[1]/KEY[2] load wins over the increment/carry.
  always_comb begin
    x_nxt   = bus.Xin;
    y_nxt   = bus.Yin;
    rgb_nxt = bus.RGBin;
`ifdef XYRGB_STEP_EN
    if (press[0]) begin
      x_nxt = bus.Xin + 8'd1;
      if (bus.Xin == 8'hFF && !press[1]) y_nxt = bus.Yin + 8'd1;
    end
`endif
    if (press[1]) x_nxt   = bus.SW[7:0];
    if (press[2]) y_nxt   = bus.SW[7:0];
    if (press[3]) rgb_nxt = bus.SW[8:0];
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      bus.Xin   <= 8'd0;
      bus.Yin   <= 8'd0;
      bus.RGBin <= 9'd0;
      bus.upd   <= 1'b0;
    end else begin
      bus.Xin   <= x_nxt;
      bus.Yin   <= y_nxt;
      bus.RGBin <= rgb_nxt;
      bus.upd   <= |press;
    end
  end
endmodule
